// File: rtl/latch_ctrl_pkg.sv
// Shared types and widths for the latch write controller.
// Holds the FSM state encoding and counter widths.
package latch_ctrl_pkg;

  localparam int CNT_W  = 8;
  localparam int WCNT_W = 16;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    PULSE,
    HOLD,
    CHECK
  } state_t;

endpackage

// File: rtl/latch_write_ctrl_phase_timer.sv
// Loadable down-counter timing one write phase.
// Ports: load/load_val set the count, zero flags terminal count.
module phase_timer
  import latch_ctrl_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             zero
);

  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= load_val;
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/latch_write_ctrl.sv
// Stream-to-latch-bank write sequencer with readback check.
// Ports: in_* stream, lat_* latch bank, busy/done/err/wr_cnt status.
module latch_write_ctrl
  import latch_ctrl_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int SETUP_CYC = 2,
  parameter int PULSE_CYC = 1,
  parameter int HOLD_CYC  = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [WIDTH-1:0]  in_data,
  output logic              in_ready,
  output logic [WIDTH-1:0]  lat_i,
  output logic              lat_en,
  input  logic [WIDTH-1:0]  lat_q,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [WCNT_W-1:0] wr_cnt
);

  localparam int CMAX = 2**CNT_W - 1;

  if (SETUP_CYC < 1 || SETUP_CYC > CMAX ||
      PULSE_CYC < 1 || PULSE_CYC > CMAX ||
      HOLD_CYC  < 1 || HOLD_CYC  > CMAX) begin : g_bad_param
    $error("latch_write_ctrl: phase counts must be 1..255");
  end

  localparam logic [CNT_W-1:0] SETUP_LD = CNT_W'(SETUP_CYC - 1);
  localparam logic [CNT_W-1:0] PULSE_LD = CNT_W'(PULSE_CYC - 1);
  localparam logic [CNT_W-1:0] HOLD_LD  = CNT_W'(HOLD_CYC - 1);

  state_t             state_q;
  state_t             state_d;
  logic               ld;
  logic [CNT_W-1:0]   ld_val;
  logic               zero;
  logic               accept;
  logic [WIDTH-1:0]   lat_i_q;
  logic               en_q;
  logic               done_q;
  logic               err_q;
  logic [WCNT_W-1:0]  wr_cnt_q;

  phase_timer u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (ld),
    .load_val (ld_val),
    .zero     (zero)
  );

  always_comb begin
    state_d = state_q;
    ld      = 1'b0;
    ld_val  = '0;
    accept  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          accept  = 1'b1;
          state_d = SETUP;
          ld      = 1'b1;
          ld_val  = SETUP_LD;
        end
      end
      SETUP: begin
        if (zero) begin
          state_d = PULSE;
          ld      = 1'b1;
          ld_val  = PULSE_LD;
        end
      end
      PULSE: begin
        if (zero) begin
          state_d = HOLD;
          ld      = 1'b1;
          ld_val  = HOLD_LD;
        end
      end
      HOLD: begin
        if (zero) state_d = CHECK;
      end
      CHECK: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Enable is registered from the next state so the latch sees a
  // clean flop output aligned exactly with the PULSE phase.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      lat_i_q  <= '0;
      en_q     <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      wr_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      en_q    <= (state_d == PULSE);
      done_q  <= (state_q == CHECK);
      if (accept) lat_i_q <= in_data;
      if (state_q == CHECK) begin
        wr_cnt_q <= wr_cnt_q + 1'b1;
        if (lat_q != lat_i_q) err_q <= 1'b1;
      end
    end
  end

  assign in_ready = (state_q == IDLE);
  assign busy     = (state_q != IDLE);
  assign lat_i    = lat_i_q;
  assign lat_en   = en_q;
  assign done     = done_q;
  assign err      = err_q;
  assign wr_cnt   = wr_cnt_q;

endmodule

// File: tb/tb_latch_write_ctrl.sv
// Directed bench for latch_write_ctrl driving a D latch bank model.
// Second instance uses longer phases for the mid-pulse reset case.
module tb_latch_write_ctrl;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic [7:0]  lat_i;
  logic        lat_en;
  logic [7:0]  lat_q;
  logic [7:0]  q1;
  logic        q_force;
  logic        busy;
  logic        done;
  logic        err;
  logic [15:0] wr_cnt;

  logic        rst2_n;
  logic        in_valid2;
  logic [7:0]  in_data2;
  logic        in_ready2;
  logic [7:0]  lat_i2;
  logic        lat_en2;
  logic [7:0]  q2;
  logic        busy2;
  logic        done2;
  logic        err2;
  logic [15:0] wr_cnt2;

  int vectors;
  int miscompares;

  latch_write_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .lat_i(lat_i), .lat_en(lat_en), .lat_q(lat_q),
    .busy(busy), .done(done), .err(err), .wr_cnt(wr_cnt)
  );

  latch_write_ctrl #(.SETUP_CYC(3), .PULSE_CYC(4)) dut2 (
    .clk(clk), .rst_n(rst2_n),
    .in_valid(in_valid2), .in_data(in_data2), .in_ready(in_ready2),
    .lat_i(lat_i2), .lat_en(lat_en2), .lat_q(q2),
    .busy(busy2), .done(done2), .err(err2), .wr_cnt(wr_cnt2)
  );

  // D latch bank models
  always_latch if (lat_en) q1 <= lat_i;
  always_latch if (lat_en2) q2 <= lat_i2;
  assign lat_q = q_force ? 8'h00 : q1;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst_n    = 1'b0;
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Accept one word, then track lat_en and done relative to the
  // accept edge (edge 0), sampling at each following negedge.
  task automatic do_write(input logic [7:0] d, output int en_start,
                          output int en_len, output int done_at);
    en_start = -1;
    en_len   = 0;
    done_at  = -1;
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = d;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    in_data  = 'x;
    for (int k = 0; k < 40; k++) begin
      if (lat_en) begin
        if (en_start < 0) en_start = k;
        en_len++;
      end
      if (done) begin
        done_at = k;
        break;
      end
      @(negedge clk);
    end
  endtask

  int es, el, da;
  int acc_n, acc1, acc2, fdone, dcnt;
  logic rdy;

  initial begin
    vectors     = 0;
    miscompares = 0;
    q_force     = 1'b0;
    in_data     = '0;
    rst2_n      = 1'b0;
    in_valid2   = 1'b0;
    in_data2    = '0;

    // 1: reset and idle
    do_reset();
    chk("rst_lat_en", lat_en, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_wr_cnt", wr_cnt, 0);
    chk("rst_err", err, 0);
    in_data = 'x;
    repeat (3) @(negedge clk);
    chk("idle_busy", busy, 0);
    chk("idle_lat_i", lat_i, 0);

    // 2: single write with default timing
    do_write(8'hA5, es, el, da);
    chk("w1_en_start", es, 2);
    chk("w1_en_len", el, 1);
    chk("w1_done_at", da, 5);
    chk("w1_lat_i", lat_i, 8'hA5);
    chk("w1_lat_q", lat_q, 8'hA5);
    chk("w1_err", err, 0);
    chk("w1_wr_cnt", wr_cnt, 1);
    @(negedge clk);
    chk("w1_done_pulse", done, 0);

    // 3: back-to-back with in_valid held
    do_reset();
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = 8'h3C;
    acc_n = 0; acc1 = -1; acc2 = -1; fdone = -1;
    for (int e = 0; e < 30; e++) begin
      rdy = in_ready;
      @(posedge clk);
      if (rdy && in_valid) begin
        if (acc_n == 0) acc1 = e;
        else acc2 = e;
        acc_n++;
      end
      @(negedge clk);
      if (acc_n == 1) in_data = 8'hC3;
      if (acc_n == 2) in_valid = 1'b0;
      if (done && fdone < 0) begin
        fdone = e;
        chk("b2b_lat_i_first", lat_i, 8'h3C);
      end
      if (done && acc_n == 2 && e > acc2) break;
    end
    in_valid = 1'b0;
    chk("b2b_acc1", acc1, 0);
    chk("b2b_first_done", fdone, 5);
    chk("b2b_acc2", acc2, 6);
    chk("b2b_acc_n", acc_n, 2);
    chk("b2b_lat_q", lat_q, 8'hC3);
    chk("b2b_wr_cnt", wr_cnt, 2);

    // 4: readback mismatch, sticky err
    do_reset();
    q_force = 1'b1;
    do_write(8'hFF, es, el, da);
    chk("mm_done_at", da, 5);
    chk("mm_err", err, 1);
    q_force = 1'b0;
    do_write(8'h5A, es, el, da);
    chk("mm_good_lat_q", lat_q, 8'h5A);
    chk("mm_err_sticky", err, 1);
    chk("mm_wr_cnt", wr_cnt, 2);

    // 5: reset during PULSE on the long-phase instance
    @(negedge clk);
    rst2_n = 1'b1;
    @(negedge clk);
    in_valid2 = 1'b1;
    in_data2  = 8'h66;
    @(posedge clk);
    @(negedge clk);
    in_valid2 = 1'b0;
    es = -1;
    for (int k = 0; k < 20; k++) begin
      if (lat_en2) begin
        es = k;
        break;
      end
      @(negedge clk);
    end
    chk("mr_en_start", es, 3);
    @(negedge clk);
    chk("mr_en_mid", lat_en2, 1);
    #1 rst2_n = 1'b0;
    #1 chk("mr_en_async", lat_en2, 0);
    chk("mr_busy", busy2, 0);
    repeat (2) @(negedge clk);
    rst2_n = 1'b1;
    dcnt = 0;
    for (int k = 0; k < 15; k++) begin
      @(negedge clk);
      if (done2) dcnt++;
    end
    chk("mr_no_done", dcnt, 0);
    chk("mr_wr_cnt", wr_cnt2, 0);

    // 6: write counter wrap
    do_reset();
    force dut.wr_cnt_q = 16'hFFFF;
    @(negedge clk);
    release dut.wr_cnt_q;
    do_write(8'h11, es, el, da);
    chk("wrap_done_at", da, 5);
    chk("wrap_wr_cnt", wr_cnt, 0);
    chk("wrap_err", err, 0);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
